// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative floating-point divider, restoring radix-2, round-to-nearest-even
// Ports: clk, clrn (async active-high reset); start accepted in IDLE, busy while working,
//        ready pulses one cycle when quotient and the flags update;
//        dividend/divisor in, quotient out (held); overflow/underflow/div_by_zero/invalid flags.
module fp_div_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] dividend,
    input  logic [EXP_W+MAN_W:0] divisor,
    output logic [EXP_W+MAN_W:0] quotient,
    output logic                 busy,
    output logic                 ready,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 div_by_zero,
    output logic                 invalid
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam int Q_W = MAN_W + 3;
    localparam int R_W = MAN_W + 2;
    localparam int E_W = EXP_W + 2;
    localparam int C_W = $clog2(Q_W);
    localparam logic [E_W-1:0] BIAS = E_W'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [E_W-1:0] EMAX = E_W'(2 ** EXP_W - 1);
    localparam logic [EXP_W-1:0] ONES = '1;

    typedef enum logic [1:0] {IDLE, DIV, ROUND} state_t;
    state_t state, nstate;

    logic sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic za, zb, ia, ib, na, nb, special, accept, inv_c;
    logic sgn, spec;
    logic [W-1:0] spec_res;
    logic [3:0] spec_flg, flg;
    logic [E_W-1:0] ex;
    logic [MAN_W-1:0] mb;
    logic [R_W-1:0] rem, r_src, d_src, r_diff;
    logic [Q_W-1:0] q;
    logic [C_W-1:0] cnt;
    logic ge, norm, g, up, carry, ovf, unf;
    logic [MAN_W-1:0] frac_n, frac_r;
    logic signed [E_W-1:0] e_fin;
    logic [W-1:0] res_c;
    logic [3:0] flg_c;

    assign {sa, ea, fa} = dividend;
    assign {sb, eb, fb} = divisor;
    assign za = ~|ea;
    assign zb = ~|eb;
    assign ia = &ea & ~|fa;
    assign ib = &eb & ~|fb;
    assign na = &ea & |fa;
    assign nb = &eb & |fb;
    assign special = za | zb | &ea | &eb;
    assign accept = state == IDLE && start;
    assign inv_c = na | nb | (za & zb) | (ia & ib);

    // The accept edge performs the first restoring step directly from the input operands,
    // so DIV only needs Q_W-1 further steps.
    assign r_src = state == IDLE ? {2'b01, fa} : rem;
    assign d_src = {2'b01, state == IDLE ? fb : mb};
    assign ge = r_src >= d_src;
    assign r_diff = ge ? r_src - d_src : r_src;

    // Without an integer bit the guard comes from q[0] and the round bit is a shifted-in 0;
    // the remainder still carries everything below, so (round | sticky) stays exact.
    assign norm = q[Q_W-1];
    assign frac_n = norm ? q[Q_W-2:2] : q[Q_W-3:1];
    assign g = norm ? q[1] : q[0];
    assign up = g & ((norm & q[0]) | (|rem) | frac_n[0]);
    assign {carry, frac_r} = {1'b0, frac_n} + (MAN_W + 1)'(up);
    assign e_fin = ex - E_W'(!norm) + E_W'(carry);
    assign ovf = !e_fin[E_W-1] && e_fin >= EMAX;
    assign unf = e_fin[E_W-1] || e_fin == '0;
    assign res_c = spec ? spec_res : ovf ? {sgn, ONES, {MAN_W{1'b0}}} :
                   unf ? {sgn, {(W - 1){1'b0}}} : {sgn, e_fin[EXP_W-1:0], frac_r};
    assign flg_c = spec ? spec_flg : {ovf, unf, 2'b00};

    assign busy = state != IDLE;
    assign {overflow, underflow, div_by_zero, invalid} = flg;

    always_comb begin
        nstate = state == IDLE ? (start ? (special ? ROUND : DIV) : IDLE) :
                 state == DIV ? (cnt == C_W'(1) ? ROUND : DIV) : IDLE;
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) state <= IDLE;
        else state <= nstate;
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            quotient <= '0;
            flg <= '0;
            ready <= 1'b0;
            sgn <= 1'b0;
            spec <= 1'b0;
            spec_res <= '0;
            spec_flg <= '0;
            ex <= '0;
            mb <= '0;
            rem <= '0;
            q <= '0;
            cnt <= '0;
        end else begin
            ready <= state == ROUND;
            if (state == ROUND) begin
                quotient <= res_c;
                flg <= flg_c;
            end
            if (accept) begin
                sgn <= sa ^ sb;
                ex <= E_W'(ea) - E_W'(eb) + BIAS;
                mb <= fb;
                cnt <= C_W'(Q_W - 1);
                spec <= special;
                spec_res <= inv_c ? {1'b0, ONES, 1'b1, {(MAN_W - 1){1'b0}}} :
                            (ia | zb) ? {sa ^ sb, ONES, {MAN_W{1'b0}}} : {sa ^ sb, {(W - 1){1'b0}}};
                spec_flg <= {2'b00, !inv_c && !ia && zb, inv_c};
            end else if (state == DIV) begin
                cnt <= cnt - C_W'(1);
            end
            if (accept || state == DIV) begin
                rem <= r_diff << 1;
                q <= {q[Q_W-2:0], ge};
            end
        end
    end
endmodule

// File: tb/tb_fp_div_iter.sv
// tb_fp_div_iter: randomized and directed checks of fp_div_iter against an arithmetic reference model
module tb_fp_div_iter;
    logic clk = 1'b0;
    logic clrn;
    logic start, h_start;
    logic [31:0] dividend, divisor, quotient;
    logic [15:0] h_dividend, h_divisor, h_quotient;
    logic busy, ready, ovf, unf, dz, inv;
    logic h_busy, h_ready, h_ovf, h_unf, h_dz, h_inv;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_div_iter dut (
        .clk(clk), .clrn(clrn), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .busy(busy), .ready(ready), .overflow(ovf), .underflow(unf),
        .div_by_zero(dz), .invalid(inv)
    );

    fp_div_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .clrn(clrn), .start(h_start), .dividend(h_dividend), .divisor(h_divisor),
        .quotient(h_quotient), .busy(h_busy), .ready(h_ready), .overflow(h_ovf), .underflow(h_unf),
        .div_by_zero(h_dz), .invalid(h_inv)
    );

    // Reference: exact integer quotient scaled to mantissa+3 bits plus remainder, then RNE.
    function automatic void model(input int ew, input int mw, input longint a, input longint b,
                                  output longint res, output logic [3:0] flg);
        longint ones, fm, ea, eb, fa, fb, sgn, e, ma, mbv, num, qt, rm, tail, mant, inf, zr;
        bit za, zb, ia, ib, na, nb, rup;
        ones = (longint'(1) << ew) - 1;
        fm = (longint'(1) << mw) - 1;
        ea = (a >> mw) & ones;
        eb = (b >> mw) & ones;
        fa = a & fm;
        fb = b & fm;
        sgn = ((a ^ b) >> (ew + mw)) & 1;
        za = ea == 0;
        zb = eb == 0;
        ia = ea == ones && fa == 0;
        ib = eb == ones && fb == 0;
        na = ea == ones && fa != 0;
        nb = eb == ones && fb != 0;
        inf = (sgn << (ew + mw)) | (ones << mw);
        zr = sgn << (ew + mw);
        flg = 4'b0000;
        if (na || nb || (za && zb) || (ia && ib)) begin
            res = (ones << mw) | (longint'(1) << (mw - 1));
            flg = 4'b0001;
        end else if (ia) begin
            res = inf;
        end else if (zb) begin
            res = inf;
            flg = 4'b0010;
        end else if (za || ib) begin
            res = zr;
        end else begin
            e = ea - eb + ((longint'(1) << (ew - 1)) - 1);
            ma = fa | (longint'(1) << mw);
            mbv = fb | (longint'(1) << mw);
            if (ma < mbv) begin
                e = e - 1;
                num = ma << (mw + 4);
            end else begin
                num = ma << (mw + 3);
            end
            qt = num / mbv;
            rm = num % mbv;
            tail = qt & 7;
            mant = qt >> 3;
            rup = tail > 4 || (tail == 4 && (rm != 0 || (mant & 1) != 0));
            mant = mant + (rup ? 1 : 0);
            if (mant == (longint'(1) << (mw + 1))) begin
                mant = mant >> 1;
                e = e + 1;
            end
            if (e >= ones) begin
                res = inf;
                flg = 4'b1000;
            end else if (e <= 0) begin
                res = zr;
                flg = 4'b0100;
            end else begin
                res = zr | (e << mw) | (mant & fm);
            end
        end
    endfunction

    function automatic bit is_special(input int ew, input int mw, input longint a, input longint b);
        longint ones, ea, eb;
        ones = (longint'(1) << ew) - 1;
        ea = (a >> mw) & ones;
        eb = (b >> mw) & ones;
        return ea == 0 || eb == 0 || ea == ones || eb == ones;
    endfunction

    function automatic longint rand_op(input int ew, input int mw);
        int onesi, k;
        longint e, f;
        onesi = (1 << ew) - 1;
        k = int'($urandom_range(0, 11));
        f = {$urandom, $urandom};
        f = f & ((longint'(1) << mw) - 1);
        e = k == 0 ? 0 : k == 1 ? longint'(onesi) : longint'($urandom_range(1, onesi - 1));
        if (k == 1 && $urandom_range(0, 1) == 0) f = 0;
        return (longint'($urandom_range(0, 1)) << (ew + mw)) | (e << mw) | f;
    endfunction

    // lat counts edges from the accept edge (counted as 1) to the edge after which ready is seen.
    task automatic run_op(input bit h, input longint a, input longint b, output longint res,
                          output logic [3:0] flg, output int lat, output int bcnt, output logic bz);
        @(negedge clk);
        if (h) begin
            h_dividend = a[15:0];
            h_divisor = b[15:0];
            h_start = 1'b1;
        end else begin
            dividend = a[31:0];
            divisor = b[31:0];
            start = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        h_start = 1'b0;
        lat = 1;
        bcnt = 0;
        while (!(h ? h_ready : ready) && lat < 100) begin
            if (h ? h_busy : busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = h ? longint'(h_quotient) : longint'(quotient);
        flg = h ? {h_ovf, h_unf, h_dz, h_inv} : {ovf, unf, dz, inv};
        bz = h ? h_busy : busy;
    endtask

    task automatic test_reset;
        clrn = 1'b1;
        start = 1'b0;
        h_start = 1'b0;
        dividend = '0;
        divisor = '0;
        h_dividend = '0;
        h_divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({quotient, busy, ready, ovf, unf, dz, inv} !== 38'd0) begin
            n_err++;
            $display("FAIL reset single outputs got %h expected 0", {quotient, busy, ready, ovf, unf, dz, inv});
        end
        n_cmp++;
        if ({h_quotient, h_busy, h_ready, h_ovf, h_unf, h_dz, h_inv} !== 22'd0) begin
            n_err++;
            $display("FAIL reset half outputs got %h expected 0", {h_quotient, h_busy, h_ready, h_ovf, h_unf, h_dz, h_inv});
        end
        @(negedge clk);
        clrn = 1'b0;
    endtask

    task automatic test_directed;
        longint va[7] = '{64'h41780000, 64'h3F800000, 64'h7F000000, 64'h00800000,
                          64'h40000000, 64'h00000000, 64'h7F800000};
        longint vb[7] = '{64'hC0400000, 64'h40400000, 64'h00800000, 64'h7F000000,
                          64'h80000000, 64'h00000000, 64'h7F800000};
        longint vr[7] = '{64'hC0A55555, 64'h3EAAAAAB, 64'h7F800000, 64'h00000000,
                          64'hFF800000, 64'h7FC00000, 64'h7FC00000};
        logic [3:0] vf[7] = '{4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001};
        longint res;
        logic [3:0] flg;
        int lat, bcnt, elat;
        logic bz;
        for (int i = 0; i < 7; i++) begin
            run_op(1'b0, va[i], vb[i], res, flg, lat, bcnt, bz);
            elat = i < 4 ? 27 : 2;
            n_cmp++;
            if (res !== vr[i]) begin
                n_err++;
                $display("FAIL dir%0d quotient got %h expected %h", i, res, vr[i]);
            end
            n_cmp++;
            if (flg !== vf[i]) begin
                n_err++;
                $display("FAIL dir%0d flags got %b expected %b", i, flg, vf[i]);
            end
            n_cmp++;
            if (lat !== elat) begin
                n_err++;
                $display("FAIL dir%0d latency got %0d expected %0d", i, lat, elat);
            end
            n_cmp++;
            if (bcnt !== elat - 1 || bz !== 1'b0) begin
                n_err++;
                $display("FAIL dir%0d busy cycles got %0d (busy@ready=%b) expected %0d (0)", i, bcnt, bz, elat - 1);
            end
        end
    endtask

    task automatic test_random(input bit h, input int n);
        int ew, mw, lat, bcnt, elat;
        longint a, b, res, eres;
        logic [3:0] flg, eflg;
        logic bz;
        ew = h ? 5 : 8;
        mw = h ? 10 : 23;
        for (int i = 0; i < n; i++) begin
            a = rand_op(ew, mw);
            b = rand_op(ew, mw);
            if (i % 4 == 0) b = (b & ~((longint'(1) << (ew + mw)) - 1)) | (((longint'(1) << (ew - 1)) - 1) << mw) | (b & 1);
            run_op(h, a, b, res, flg, lat, bcnt, bz);
            model(ew, mw, a, b, eres, eflg);
            elat = is_special(ew, mw, a, b) ? 2 : mw + 4;
            n_cmp++;
            if (res !== eres || flg !== eflg || lat !== elat) begin
                n_err++;
                $display("FAIL rand%s %h/%h got q=%h f=%b lat=%0d expected q=%h f=%b lat=%0d",
                         h ? "_half" : "", a, b, res, flg, lat, eres, eflg, elat);
            end
        end
    endtask

    task automatic test_start_ignored;
        longint res, eres;
        logic [3:0] eflg;
        int n, extra;
        @(negedge clk);
        dividend = 32'h40490FDB;
        divisor = 32'h402DF854;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        dividend = 32'h3F800000;
        divisor = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        res = longint'(quotient);
        model(8, 23, 64'h40490FDB, 64'h402DF854, eres, eflg);
        n_cmp++;
        if (res !== eres || {ovf, unf, dz, inv} !== eflg) begin
            n_err++;
            $display("FAIL start_ignored quotient got %h flags %b expected %h flags %b", res, {ovf, unf, dz, inv}, eres, eflg);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready || busy) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL start_ignored extra activity cycles got %0d expected 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        longint res1, res2, e1, e2;
        logic [3:0] f1, f2;
        int n, m;
        model(8, 23, 64'h41200000, 64'h40E00000, e1, f1);
        model(8, 23, 64'hC2F60000, 64'h3DCCCCCD, e2, f2);
        @(negedge clk);
        dividend = 32'h41200000;
        divisor = 32'h40E00000;
        start = 1'b1;
        @(posedge clk);
        #1;
        dividend = 32'hC2F60000;
        divisor = 32'h3DCCCCCD;
        n = 1;
        while (!ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        res1 = longint'(quotient);
        @(posedge clk);
        #1;
        start = 1'b0;
        m = 1;
        while (!ready && m < 100) begin
            @(posedge clk);
            #1;
            m++;
        end
        res2 = longint'(quotient);
        n_cmp++;
        if (res1 !== e1 || n !== 27) begin
            n_err++;
            $display("FAIL b2b first got %h lat %0d expected %h lat 27", res1, n, e1);
        end
        n_cmp++;
        if (res2 !== e2 || {ovf, unf, dz, inv} !== f2) begin
            n_err++;
            $display("FAIL b2b second got %h flags %b expected %h flags %b", res2, {ovf, unf, dz, inv}, e2, f2);
        end
        n_cmp++;
        if (m !== 27) begin
            n_err++;
            $display("FAIL b2b spacing got %0d expected 27", m);
        end
    endtask

    task automatic test_reset_mid;
        longint res, eres;
        logic [3:0] flg, eflg;
        int lat, bcnt, pulses;
        logic bz;
        @(negedge clk);
        dividend = 32'h42C80000;
        divisor = 32'h41100000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        clrn = 1'b1;
        #1;
        n_cmp++;
        if ({quotient, busy, ready, ovf, unf, dz, inv} !== 38'd0) begin
            n_err++;
            $display("FAIL reset_mid outputs got %h expected 0", {quotient, busy, ready, ovf, unf, dz, inv});
        end
        @(negedge clk);
        clrn = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL reset_mid ready pulses got %0d expected 0", pulses);
        end
        run_op(1'b0, 64'h42C80000, 64'h41100000, res, flg, lat, bcnt, bz);
        model(8, 23, 64'h42C80000, 64'h41100000, eres, eflg);
        n_cmp++;
        if (res !== eres || flg !== eflg || lat !== 27) begin
            n_err++;
            $display("FAIL reset_mid next op got %h f=%b lat=%0d expected %h f=%b lat=27", res, flg, lat, eres, eflg);
        end
    endtask

    task automatic test_half;
        longint res;
        logic [3:0] flg;
        int lat, bcnt;
        logic bz;
        run_op(1'b1, 64'h3C00, 64'h4000, res, flg, lat, bcnt, bz);
        n_cmp++;
        if (res !== 64'h3800 || flg !== 4'b0000 || lat !== 14) begin
            n_err++;
            $display("FAIL half_div quotient got %h f=%b lat=%0d expected 3800 f=0000 lat=14", res, flg, lat);
        end
        run_op(1'b1, 64'h7BFF, 64'h0400, res, flg, lat, bcnt, bz);
        n_cmp++;
        if (res !== 64'h7C00 || flg !== 4'b1000) begin
            n_err++;
            $display("FAIL half_ovf quotient got %h f=%b expected 7c00 f=1000", res, flg);
        end
        test_random(1'b1, 150);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog timeout after %0d comparisons", n_cmp);
        $fatal(1);
    end

    initial begin
        test_reset;
        test_directed;
        test_random(1'b0, 300);
        test_start_ignored;
        test_back_to_back;
        test_reset_mid;
        test_half;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
